// File: rtl/tea_pkg.sv
// tea_pkg: shared TEA constants, state/block types and the round-mix helper
package tea_pkg;
    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef logic [63:0] block_t;
    function automatic logic [31:0] tea_f(input logic [31:0] v, a, b, s);
        return ((v << 4) + a) ^ (v + s) ^ ((v >> 5) + b);
    endfunction
endpackage

// File: rtl/tea_if.sv
// tea_if: block-in / block-out handshake bundle for tea_core
interface tea_if;
    import tea_pkg::*;
    logic in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [127:0] key;
    block_t din, dout;
    modport master(output in_valid, mode, key, din, out_ready,
                   input in_ready, out_valid, dout, busy);
    modport slave(input in_valid, mode, key, din, out_ready,
                  output in_ready, out_valid, dout, busy);
endinterface

// File: rtl/tea_round.sv
// tea_round: one combinational TEA cycle, encrypt or decrypt
module tea_round import tea_pkg::*; #(
    parameter logic [31:0] DELTA = TEA_DELTA
) (
    input  logic         mode_i,
    input  logic [31:0]  y_i,
    input  logic [31:0]  z_i,
    input  logic [31:0]  sum_i,
    input  logic [127:0] key_i,
    output logic [31:0]  y_o,
    output logic [31:0]  z_o,
    output logic [31:0]  sum_o
);
    logic [31:0] k0, k1, k2, k3, s_enc, y_enc, z_dec;
    assign {k0, k1, k2, k3} = key_i;
    assign s_enc = sum_i + DELTA;
    assign y_enc = y_i + tea_f(z_i, k0, k1, s_enc);
    // decrypt undoes z first, then y with the already-restored z
    assign z_dec = z_i - tea_f(y_i, k2, k3, sum_i);
    assign y_o   = mode_i ? y_i - tea_f(z_dec, k0, k1, sum_i) : y_enc;
    assign z_o   = mode_i ? z_dec : z_i + tea_f(y_enc, k2, k3, s_enc);
    assign sum_o = mode_i ? sum_i - DELTA : s_enc;
endmodule

// File: rtl/tea_core.sv
// tea_core: iterative TEA block cipher, UNROLL cycles per clock
module tea_core import tea_pkg::*; #(
    parameter int          ROUNDS = 32,
    parameter int          UNROLL = 1,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input logic clk,
    input logic rst,
    tea_if.slave bus
);
    localparam int N  = ROUNDS / UNROLL;
    localparam int CW = $clog2(N + 1);
    localparam logic [31:0] SUM_DEC = DELTA * 32'(ROUNDS);
    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    y_q, y_d, z_q, z_d, sum_q, sum_d;
    logic [127:0]   key_q, key_d;
    logic           mode_q, mode_d;
    logic [31:0]    yc [UNROLL+1];
    logic [31:0]    zc [UNROLL+1];
    logic [31:0]    sc [UNROLL+1];
    assign yc[0] = y_q;
    assign zc[0] = z_q;
    assign sc[0] = sum_q;
    for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
        tea_round #(.DELTA(DELTA)) u_rnd (
            .mode_i(mode_q), .y_i(yc[g]), .z_i(zc[g]), .sum_i(sc[g]), .key_i(key_q),
            .y_o(yc[g+1]), .z_o(zc[g+1]), .sum_o(sc[g+1])
        );
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        z_d     = z_q;
        sum_d   = sum_q;
        key_d   = key_q;
        mode_d  = mode_q;
        if (state_q == IDLE && bus.in_valid) begin
            state_d    = RUN;
            cnt_d      = '0;
            {y_d, z_d} = bus.din;
            key_d      = bus.key;
            mode_d     = bus.mode;
            sum_d      = bus.mode ? SUM_DEC : '0;
        end else if (state_q == RUN) begin
            y_d     = yc[UNROLL];
            z_d     = zc[UNROLL];
            sum_d   = sc[UNROLL];
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(N - 1)) ? DONE : RUN;
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            z_q     <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            z_q     <= z_d;
            sum_q   <= sum_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.dout      = {y_q, z_q};
endmodule

// File: tb/tb_tea_core.sv
// tb_tea_core: directed and round-trip checks of tea_core at UNROLL 1, 2, 4
module tb_tea_core;
    import tea_pkg::*;
    localparam logic [63:0] CT0 = 64'h41EA3A0A_94BAA940;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv [3];
    logic ordy [3];
    logic ir [3];
    logic ov [3];
    logic bz [3];
    logic [63:0] dq [3];
    logic mode;
    logic [127:0] key;
    logic [63:0] din;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        tea_if bus();
        assign bus.in_valid  = iv[g];
        assign bus.out_ready = ordy[g];
        assign bus.mode      = mode;
        assign bus.key       = key;
        assign bus.din       = din;
        assign ir[g] = bus.in_ready;
        assign ov[g] = bus.out_valid;
        assign bz[g] = bus.busy;
        assign dq[g] = bus.dout;
        tea_core #(.ROUNDS(32), .UNROLL(1 << g)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    end
    function automatic logic [63:0] tea_ref(input logic m, input logic [127:0] k, input logic [63:0] d);
        logic [31:0] y, z, s, k0, k1, k2, k3;
        {y, z} = d;
        {k0, k1, k2, k3} = k;
        s = m ? 32'hC6EF3720 : 32'h0;
        for (int i = 0; i < 32; i++) begin
            if (!m) begin
                s += 32'h9E3779B9;
                y += ((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1);
                z += ((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3);
            end else begin
                z -= ((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3);
                y -= ((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1);
                s -= 32'h9E3779B9;
            end
        end
        return {y, z};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic run(input int u, input logic m, input logic [127:0] k, input logic [63:0] d,
                       output logic [63:0] r, output int lat);
        mode = m;
        key = k;
        din = d;
        iv[u] = 1'b1;
        step();
        iv[u] = 1'b0;
        lat = 1;
        while (!ov[u] && lat < 100) begin
            step();
            lat++;
        end
        r = dq[u];
        ordy[u] = 1'b1;
        step();
        ordy[u] = 1'b0;
    endtask
    initial begin
        logic [63:0] r, r2, d, e;
        logic [127:0] k;
        logic [63:0] bb [4];
        logic [63:0] be [4];
        logic seen;
        int lat, na, nr, last;
        for (int u = 0; u < 3; u++) begin
            iv[u] = 1'b0;
            ordy[u] = 1'b0;
        end
        mode = 1'b0;
        key = '0;
        din = '0;
        repeat (2) step();
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_in_ready u%0d", u), 64'(ir[u]), 64'd1);
            chk($sformatf("rst_out_valid u%0d", u), 64'(ov[u]), 64'd0);
            chk($sformatf("rst_busy u%0d", u), 64'(bz[u]), 64'd0);
            chk($sformatf("rst_dout u%0d", u), dq[u], 64'd0);
        end
        for (int u = 0; u < 3; u++) begin
            run(u, 1'b0, '0, '0, r, lat);
            chk($sformatf("enc_zero u%0d", u), r, CT0);
            chk($sformatf("enc_lat u%0d", u), 64'(lat), 64'(32 / (1 << u) + 1));
            run(u, 1'b1, '0, CT0, r, lat);
            chk($sformatf("dec_zero u%0d", u), r, 64'd0);
            chk($sformatf("dec_lat u%0d", u), 64'(lat), 64'(32 / (1 << u) + 1));
        end
        mode = 1'b0;
        key = '0;
        din = '0;
        iv[0] = 1'b1;
        step();
        din = 64'hDEADBEEF_CAFEF00D;
        key = '1;
        mode = 1'b1;
        seen = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 100) begin
            seen |= ir[0];
            step();
            lat++;
        end
        chk("bp_in_ready_run", 64'(seen), 64'd0);
        chk("bp_lat", 64'(lat), 64'd33);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_out_valid %0d", i), 64'(ov[0]), 64'd1);
            chk($sformatf("bp_dout %0d", i), dq[0], CT0);
            chk($sformatf("bp_in_ready %0d", i), 64'(ir[0]), 64'd0);
            step();
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        step();
        ordy[0] = 1'b0;
        chk("bp_release_in_ready", 64'(ir[0]), 64'd1);
        chk("bp_release_out_valid", 64'(ov[0]), 64'd0);
        mode = 1'b0;
        key = '0;
        din = 64'h01234567_89ABCDEF;
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        repeat (9) step();
        chk("mid_busy", 64'(bz[0]), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", 64'(ir[0]), 64'd1);
        chk("mid_rst_out_valid", 64'(ov[0]), 64'd0);
        chk("mid_rst_busy", 64'(bz[0]), 64'd0);
        chk("mid_rst_dout", dq[0], 64'd0);
        run(0, 1'b0, '0, '0, r, lat);
        chk("post_rst_enc", r, CT0);
        chk("post_rst_lat", 64'(lat), 64'd33);
        bb[0] = '0;
        for (int i = 1; i < 4; i++) bb[i] = {$urandom, $urandom};
        mode = 1'b0;
        key = '0;
        din = bb[0];
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        na = 0;
        nr = 0;
        last = 0;
        for (int c = 0; c < 300 && nr < 4; c++) begin
            automatic logic acc = ir[0] && iv[0];
            if (ov[0]) begin
                chk($sformatf("b2b_dout %0d", nr), dq[0], be[nr]);
                nr++;
            end
            if (acc) begin
                if (na > 0) chk($sformatf("b2b_gap %0d", na), 64'(c - last), 64'd34);
                last = c;
                be[na] = tea_ref(1'b0, '0, bb[na]);
                na++;
            end
            step();
            if (acc) begin
                if (na < 4) din = bb[na];
                else iv[0] = 1'b0;
            end
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        chk("b2b_results", 64'(nr), 64'd4);
        chk("b2b_first_vector", be[0], CT0);
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 200; i++) begin
                k = {$urandom, $urandom, $urandom, $urandom};
                d = {$urandom, $urandom};
                e = tea_ref(1'b0, k, d);
                run(u, 1'b0, k, d, r, lat);
                chk($sformatf("rt_enc u%0d i%0d", u, i), r, e);
                chk($sformatf("rt_enc_lat u%0d i%0d", u, i), 64'(lat), 64'(32 / (1 << u) + 1));
                run(u, 1'b1, k, r, r2, lat);
                chk($sformatf("rt_dec u%0d i%0d", u, i), r2, d);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
